cp0_exc_ctrl: RTL and testbench

Exception/interrupt controller for the pipelined CPU's coprocessor 0. It owns the Status, Cause and EPC registers and arbitrates overflow, syscall and external-interrupt requests. It drives PC redirect and pipeline flush, and services mtc0/mfc0/eret from the ID stage. It sits beside the ID/EXE stages and feeds the PC-select mux.

---
 rtl/cp0_exc_ctrl_pkg.sv | 35 +++
 rtl/cp0_exc_ctrl_sync.sv | 28 ++
 rtl/dff32e.sv | 20 ++
 rtl/cp0_exc_ctrl.sv | 134 +++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 shared definitions: register select codes, ExcCode values, Status bit map.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package cp0_exc_ctrl_pkg;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;
    localparam logic [1:0] SEL_NONE   = 2'd3;

    localparam logic [1:0] EXC_INT = 2'b00;
    localparam logic [1:0] EXC_SYS = 2'b01;
    localparam logic [1:0] EXC_OVF = 2'b11;

    localparam int ST_IE  = 0;
    localparam int ST_INT = 1;
    localparam int ST_SYS = 2;
    localparam int ST_OVF = 3;
    localparam int ST_PIE = 4;

    localparam logic [31:0] STATUS_MASK = 32'h0000_001F;
    localparam logic [31:0] CAUSE_MASK  = 32'h0000_000C;
    localparam logic [31:0] VECTOR_DEF  = 32'h0000_0008;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BLOCK = 1'b1
    } state_t;

    // Cause register image for a given ExcCode (code lives in bits [3:2]).
    function automatic logic [31:0] cause_word(input logic [1:0] code);
        return {28'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt level.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running.
module cp0_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/dff32e.sv
// 32-bit register with write enable and async active-low clear.
// Latency: q follows d one edge after we=1.
// Backpressure: none; holds value while we=0.
module dff32e (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: Status/Cause/EPC, ovf>sys>int arbitration, eret, mtc0/mfc0.
// Latency: redirect/flush/rdata combinational in the accept cycle; CP0 registers update at the next edge.
// Backpressure: stall=1 holds off every accept, eret and mtc0; BLOCK ignores all for one cycle after an accept.
// Ports: clk/resetn; intr (async level); stall; id_pc/id_bd/id_sys; exe_pc/exe_ovf; mtc0/eret/sel/wdata;
//        rdata (mfc0 read mux); redirect/exc_target to the PC mux; flush_id/flush_exe to the pipeline regs.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR      = VECTOR_DEF,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        intr,
    input  logic        stall,
    input  logic [31:0] id_pc,
    input  logic        id_bd,
    input  logic        id_sys,
    input  logic [31:0] exe_pc,
    input  logic        exe_ovf,
    input  logic        mtc0,
    input  logic        eret,
    input  logic [1:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        redirect,
    output logic [31:0] exc_target,
    output logic        flush_id,
    output logic        flush_exe
);

    logic [31:0] status, cause, epc;
    logic [31:0] status_d, cause_d, epc_d;
    logic        status_we, cause_we, epc_we;
    logic        intr_s;
    state_t      state, state_nxt;

    logic        idle_go;
    logic        open_win;
    logic        c_ovf, c_sys, c_int, accept;
    logic        do_eret, do_mtc0;
    logic [1:0]  code;

    cp0_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (intr),
        .q      (intr_s)
    );

    dff32e u_status (.clk(clk), .resetn(resetn), .we(status_we), .d(status_d), .q(status));
    dff32e u_cause  (.clk(clk), .resetn(resetn), .we(cause_we),  .d(cause_d),  .q(cause));
    dff32e u_epc    (.clk(clk), .resetn(resetn), .we(epc_we),    .d(epc_d),    .q(epc));

    // resetn is folded in so every combinational output reads 0 while reset is held.
    assign idle_go  = resetn && (state == S_IDLE) && !stall;
    assign open_win = idle_go && status[ST_IE];

    assign c_ovf  = open_win && exe_ovf && status[ST_OVF];
    assign c_sys  = open_win && id_sys  && status[ST_SYS];
    // Interrupts are not taken on a delay slot: EPC would skip the branch.
    assign c_int  = open_win && intr_s  && status[ST_INT] && !id_bd;
    assign accept = c_ovf || c_sys || c_int;

    assign do_eret = idle_go && eret && !accept;
    assign do_mtc0 = idle_go && mtc0 && !accept && !eret;

    assign code = c_ovf ? EXC_OVF : (c_sys ? EXC_SYS : EXC_INT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        status_d  = status;
        cause_d   = cause;
        epc_d     = epc;
        status_we = 1'b0;
        cause_we  = 1'b0;
        epc_we    = 1'b0;

        if (accept) begin
            state_nxt        = S_BLOCK;
            epc_d            = c_ovf ? exe_pc : id_pc;
            cause_d          = cause_word(code);
            status_d[ST_PIE] = status[ST_IE];
            status_d[ST_IE]  = 1'b0;
            status_we        = 1'b1;
            cause_we         = 1'b1;
            epc_we           = 1'b1;
        end else if (do_eret) begin
            status_d[ST_IE]  = status[ST_PIE];
            status_we        = 1'b1;
        end else if (do_mtc0) begin
            case (sel)
                SEL_STATUS: begin
                    status_d  = wdata & STATUS_MASK;
                    status_we = 1'b1;
                end
                SEL_CAUSE: begin
                    cause_d  = wdata & CAUSE_MASK;
                    cause_we = 1'b1;
                end
                SEL_EPC: begin
                    epc_d  = wdata;
                    epc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_STATUS: rdata = status;
            SEL_CAUSE:  rdata = cause;
            SEL_EPC:    rdata = epc;
            default:    rdata = '0;
        endcase
    end

    assign redirect   = accept || do_eret;
    assign flush_id   = accept || do_eret;
    // Only overflow is detected in EXE, so only it squashes the ID/EXE register.
    assign flush_exe  = c_ovf;
    assign exc_target = !resetn ? 32'd0 : (accept ? VECTOR : epc);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus random traffic vs a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cp0_exc_ctrl;

    localparam int          SYNC = 2;
    localparam logic [31:0] VEC  = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        resetn, intr, stall, id_bd, id_sys, exe_ovf, mtc0, eret;
    logic [31:0] id_pc, exe_pc, wdata;
    logic [1:0]  sel;
    logic [31:0] rdata, exc_target;
    logic        redirect, flush_id, flush_exe;

    cp0_exc_ctrl #(.VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .intr       (intr),
        .stall      (stall),
        .id_pc      (id_pc),
        .id_bd      (id_bd),
        .id_sys     (id_sys),
        .exe_pc     (exe_pc),
        .exe_ovf    (exe_ovf),
        .mtc0       (mtc0),
        .eret       (eret),
        .sel        (sel),
        .wdata      (wdata),
        .rdata      (rdata),
        .redirect   (redirect),
        .exc_target (exc_target),
        .flush_id   (flush_id),
        .flush_exe  (flush_exe)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Architectural model: register values, "last cycle accepted" flag, recent intr samples.
    bit [31:0] m_st, m_ca, m_epc;
    bit        m_blk;
    bit        hist [SYNC];

    logic [31:0] o_rdata, o_tgt;
    logic        o_redir, o_fid, o_fexe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge: checks mid-cycle, advances the model, returns #1 after the next edge.
    task automatic step();
        int        ev;
        bit        er, wr, e_redir;
        bit [31:0] e_tgt, e_rd;
        #4;
        if (!resetn) begin
            m_st = 0; m_ca = 0; m_epc = 0; m_blk = 0;
            for (int i = 0; i < SYNC; i++) hist[i] = 0;
        end
        ev = -1;
        if (resetn && !m_blk && m_st[0] && !stall) begin
            if (exe_ovf && m_st[3])                      ev = 3;
            else if (id_sys && m_st[2])                  ev = 1;
            else if (hist[SYNC-1] && m_st[1] && !id_bd)  ev = 0;
        end
        er = resetn && !m_blk && !stall && eret && (ev < 0);
        wr = resetn && !m_blk && !stall && mtc0 && (ev < 0) && !eret;
        e_redir = (ev >= 0) || er;
        e_tgt   = !resetn ? 32'd0 : ((ev >= 0) ? VEC : m_epc);
        case (sel)
            2'd0:    e_rd = m_st;
            2'd1:    e_rd = m_ca;
            2'd2:    e_rd = m_epc;
            default: e_rd = 0;
        endcase

        o_rdata = rdata; o_tgt = exc_target;
        o_redir = redirect; o_fid = flush_id; o_fexe = flush_exe;

        chk("redirect",  32'(redirect),  32'(e_redir));
        chk("flush_id",  32'(flush_id),  32'(e_redir));
        chk("flush_exe", 32'(flush_exe), 32'(ev == 3));
        chk("rdata",     rdata,          e_rd);
        if (e_redir || !resetn) chk("exc_target", exc_target, e_tgt);

        if (resetn) begin
            if (ev >= 0) begin
                m_epc = (ev == 3) ? exe_pc : id_pc;
                m_ca  = 32'(ev) << 2;
                m_st  = (m_st & ~32'h11) | (m_st[0] ? 32'h10 : 32'h0);
            end else if (er) begin
                m_st  = (m_st & ~32'h1) | 32'(m_st[4]);
            end else if (wr) begin
                case (sel)
                    2'd0:    m_st  = wdata & 32'h1F;
                    2'd1:    m_ca  = wdata & 32'hC;
                    2'd2:    m_epc = wdata;
                    default: ;
                endcase
            end
            m_blk = (ev >= 0);
            for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = intr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        resetn = 0; intr = 0; stall = 0; id_bd = 0; id_sys = 0; exe_ovf = 0;
        mtc0 = 0; eret = 0; sel = 0; id_pc = 0; exe_pc = 0; wdata = 0;
        @(posedge clk); #1;

        // Reset: every readable register is 0, even with reset held.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); step(); chk("rst_rdata", o_rdata, 32'h0);
        end
        resetn = 1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); step(); chk("post_rst_rdata", o_rdata, 32'h0);
        end

        // All sources disabled: interrupt must be ignored.
        sel = 0; intr = 1; seen = 0;
        repeat (20) begin step(); seen += int'(o_redir); end
        chk("int_disabled_redirects", 32'(seen), 32'h0);
        intr = 0; step(); step();

        // Interrupt accepted SYNC cycles after intr rises.
        mtc0 = 1; sel = 0; wdata = 32'h3; step(); mtc0 = 0;
        intr = 1; id_pc = 32'h40;
        step(); step(); step();
        chk("int_redirect", 32'(o_redir), 32'h1);
        chk("int_target",   o_tgt,        32'h8);
        chk("int_flush_id", 32'(o_fid),   32'h1);
        intr = 0;
        sel = 2; step(); chk("int_epc",    o_rdata, 32'h40);
        sel = 1; step(); chk("int_cause",  o_rdata, 32'h0);
        sel = 0; step(); chk("int_status", o_rdata, 32'h12);

        // Overflow beats simultaneous syscall.
        mtc0 = 1; sel = 0; wdata = 32'hF; step(); mtc0 = 0;
        exe_ovf = 1; exe_pc = 32'h20; id_sys = 1; id_pc = 32'h44;
        step();
        chk("ovf_redirect",  32'(o_redir), 32'h1);
        chk("ovf_flush_exe", 32'(o_fexe),  32'h1);
        exe_ovf = 0; id_sys = 0;
        sel = 2; step(); chk("ovf_epc",   o_rdata, 32'h20);
        sel = 1; step(); chk("ovf_cause", o_rdata, 32'hC);

        // Interrupt held off across delay slots.
        mtc0 = 1; sel = 0; wdata = 32'h3; step(); mtc0 = 0;
        intr = 1; id_bd = 1; id_pc = 32'h58; seen = 0;
        repeat (4) begin step(); seen += int'(o_redir); end
        chk("bd_no_accept", 32'(seen), 32'h0);
        id_bd = 0; step();
        chk("bd_redirect", 32'(o_redir), 32'h1);
        sel = 2; step(); chk("bd_epc", o_rdata, 32'h58);

        // eret with intr still pending: eret first, then the interrupt.
        eret = 1; sel = 0; step();
        chk("eret_redirect", 32'(o_redir), 32'h1);
        chk("eret_target",   o_tgt,        32'h58);
        chk("eret_status",   o_rdata,      32'h12);
        eret = 0; step();
        chk("eret_then_int", 32'(o_redir), 32'h1);
        chk("eret_int_tgt",  o_tgt,        32'h8);
        chk("eret_ie_back",  o_rdata,      32'h13);
        intr = 0; step();

        // Syscall waits out a stall, then reset during BLOCK.
        mtc0 = 1; sel = 0; wdata = 32'h5; step(); mtc0 = 0;
        id_sys = 1; stall = 1; id_pc = 32'h60; seen = 0;
        repeat (3) begin step(); seen += int'(o_redir); end
        chk("stall_no_accept", 32'(seen), 32'h0);
        stall = 0; step();
        chk("stall_release_accept", 32'(o_redir), 32'h1);
        id_sys = 0; resetn = 0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s); step(); chk("block_reset_rdata", o_rdata, 32'h0);
        end
        resetn = 1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            resetn  = ($urandom_range(0, 199) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            id_sys  = ($urandom_range(0, 5) == 0);
            exe_ovf = ($urandom_range(0, 6) == 0);
            id_bd   = ($urandom_range(0, 3) == 0);
            mtc0    = ($urandom_range(0, 4) == 0);
            eret    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) intr = ~intr;
            sel    = 2'($urandom_range(0, 3));
            wdata  = $urandom;
            id_pc  = $urandom & 32'hFFFF_FFFC;
            exe_pc = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
